pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Central stall and flush controller for the 5-stage RISC-V pipeline. It merges three hazard sources into the 6-bit `stall` vector and the `br` flush consumed by every inter-stage register:
- load-use detection in ID;
- a multi-cycle EX operation counter;
- a data-memory wait FSM with timeout.

It also keeps a stall-cycle performance counter.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: maximum cycles spent in memory wait before forced release (1..255).
- `MC_W`, 5: width of the multi-cycle length field.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID
- `id_use_rs1`, `id_use_rs2`  in  1 each  ID instruction reads rs1 / rs2
- `ex_rd`  in  5  destination register of the instruction in EX
- `ex_mem_read`  in  1  instruction in EX is a load
- `ex_br_taken`  in  1  branch/jump in EX redirects the PC
- `ex_mc_start`  in  1  EX begins a multi-cycle op (one-cycle pulse)
- `ex_mc_cycles`  in  MC_W  extra cycles the op needs
- `mem_req`  in  1  valid load/store in MEM
- `dmem_ready`  in  1  data memory completes the access this cycle
- `stall`  out  6  stage hold vector: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB
- `br`  out  1  flush IF/ID and ID/EX
- `mem_timeout`  out  1  one-cycle pulse, memory wait aborted
- `stall_cnt`  out  32  cycles with `stall[0]`=1, wraps

## Operation
- Stall encoding is a prefix. Stage register i→i+1 holds when `stall[i+1]`, and bubbles when `stall[i] && !stall[i+1]`.
- Sources and the vectors they drive:
  - load-use → `6'b000111`
  - EX busy → `6'b001111`
  - MEM wait → `6'b011111`
  - none → `6'b000000`
- When several sources are active, the deepest one wins. `stall[5]` is always 0.
- Load-use hazard:
  - Condition: `ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd))`.
  - It is ignored while `br`=1, because the ID instruction is being flushed.
- Multi-cycle EX:
  - `ex_mc_start` with N>0 while `mc_cnt`=0 and `stall[3]`=0 loads `mc_cnt`←N.
  - EX busy = (`mc_cnt`≠0). `mc_cnt` decrements each cycle while nonzero.
  - Starting an op with N cycles holds EX for exactly N cycles after the start cycle.
  - N=0 and starts arriving while busy or stalled are ignored.
- Memory FSM, states `M_IDLE` and `M_WAIT`:
  - `M_IDLE`: if `mem_req && !dmem_ready`, MEM wait=1 this cycle, go to `M_WAIT`, `to_cnt`←1.
  - `M_WAIT`: MEM wait=1 and `to_cnt`++.
    - `dmem_ready`=1 → MEM wait=0 this cycle, go to `M_IDLE`.
    - `to_cnt`==`MEM_TIMEOUT` without ready → `mem_timeout`=1, MEM wait=0, go to `M_IDLE`.
  - If `mem_req` drops in `M_WAIT`, go to `M_IDLE` with no stall.
- Flush: `br = ex_br_taken && !stall[3]`. A branch held in a stalled EX flushes only on the cycle EX advances.
- `stall_cnt` increments on each clock edge where `stall[0]`=1.

## Timing
- `stall`, `br` and `mem_timeout` are combinational from current state and inputs, so they act on the same edge.
- `mc_cnt`, the FSM state, `to_cnt` and `stall_cnt` are registered.
- Reset (async, `rst_n`=0):
  - `mc_cnt`=0, FSM=`M_IDLE`, `to_cnt`=0, `stall_cnt`=0.
  - `stall`=0, `br`=0 and `mem_timeout`=0 are forced while `rst_n` is low.
- Reset mid-wait or mid-op abandons it. No stall is asserted after release until a new source appears.
- `ex_mc_start` and `dmem_ready` in the same cycle are independent. The MEM stall dominates the vector, and `mc_cnt` keeps counting during a MEM stall.
- `stall_cnt` wraps from `32'hFFFF_FFFF` to 0.

## Configuration
- `PIPE_MC_EX_EN` defined:
  - The multi-cycle EX counter is built.
  - `ex_mc_start` and `ex_mc_cycles` are honoured as above.
- `PIPE_MC_EX_EN` undefined:
  - No `mc_cnt` register; EX busy is constant 0.
  - `ex_mc_start` and `ex_mc_cycles` are ignored, and `stall[3]` is driven only by MEM wait.

## Test plan
- Load-use:
  - Stimulus: `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_use_rs1`=1 for one cycle.
  - Required: `stall`=`6'b000111` that cycle, then `6'b000000` once EX no longer holds the load.
- Load-use during branch:
  - Stimulus: the load-use condition above with `ex_br_taken`=1.
  - Required: `stall`=0, `br`=1.
- Multi-cycle EX (`PIPE_MC_EX_EN` defined):
  - Stimulus: `ex_mc_start`=1, `ex_mc_cycles`=3.
  - Required: `stall`=`6'b001111` for the next 3 cycles, then 0.
  - Required: `ex_br_taken` held high gives `br`=0 during those 3 cycles and 1 after.
- Memory wait:
  - Stimulus: `mem_req`=1 with `dmem_ready` low for 4 cycles, then high.
  - Required: `stall`=`6'b011111` for 4 cycles, 0 on the ready cycle.
  - Required: `stall_cnt` advances by 4.
- Memory timeout (`MEM_TIMEOUT`=8):
  - Stimulus: `mem_req`=1, `dmem_ready`=0 held.
  - Required: stall on the entry cycle and 7 further cycles, a `mem_timeout` pulse on cycle 8, FSM back in `M_IDLE`.
- Reset mid-op:
  - Stimulus: `rst_n` low during `mc_cnt`=2 and `M_WAIT`.
  - Required: `stall`=0 immediately, `stall_cnt`=0.
  - Required: no stall after release while inputs are quiet.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, multi-cycle EX and data-memory wait.
// Optional feature macro: PIPE_MC_EX_EN builds the multi-cycle EX counter.
module pipe_stall_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int MC_W        = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_mem_read,
    input  logic            ex_br_taken,
    input  logic            ex_mc_start,
    input  logic [MC_W-1:0] ex_mc_cycles,
    input  logic            mem_req,
    input  logic            dmem_ready,
    output logic [5:0]      stall,
    output logic            br,
    output logic            mem_timeout,
    output logic [31:0]     stall_cnt
);

    localparam logic [0:0] M_IDLE   = 1'b0;
    localparam logic [0:0] M_WAIT   = 1'b1;
    localparam logic [7:0] TO_LIMIT = 8'(MEM_TIMEOUT);

    logic [0:0]  mstate_q, mstate_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        mem_wait_s;
    logic        mem_to_s;
    logic        ex_busy_s;
    logic        br_raw_s;
    logic        load_use_s;
    logic [5:0]  stall_s;

    // Memory wait FSM: next state, timeout counter and the MEM wait / timeout decisions.
    always_comb begin
        mstate_d   = mstate_q;
        to_cnt_d   = to_cnt_q;
        mem_wait_s = 1'b0;
        mem_to_s   = 1'b0;
        case (mstate_q)
            M_IDLE: begin
                if (mem_req && !dmem_ready) begin
                    mem_wait_s = 1'b1;
                    mstate_d   = M_WAIT;
                    to_cnt_d   = 8'd1;
                end else begin
                    mstate_d   = M_IDLE;
                    to_cnt_d   = 8'd0;
                end
            end
            M_WAIT: begin
                if (!mem_req || dmem_ready) begin
                    mstate_d = M_IDLE;
                    to_cnt_d = 8'd0;
                end else if (to_cnt_q == TO_LIMIT) begin
                    mem_to_s = 1'b1;
                    mstate_d = M_IDLE;
                    to_cnt_d = 8'd0;
                end else begin
                    mem_wait_s = 1'b1;
                    to_cnt_d   = to_cnt_q + 8'd1;
                end
            end
            default: begin
                mstate_d = M_IDLE;
                to_cnt_d = 8'd0;
            end
        endcase
    end

`ifdef PIPE_MC_EX_EN
    logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;

    // Multi-cycle EX countdown; a new op only starts when EX is free and not held by MEM.
    always_comb begin
        mc_cnt_d = mc_cnt_q;
        if (mc_cnt_q != {MC_W{1'b0}}) begin
            mc_cnt_d = mc_cnt_q - MC_W'(1);
        end else if (ex_mc_start && (ex_mc_cycles != {MC_W{1'b0}}) && !mem_wait_s) begin
            mc_cnt_d = ex_mc_cycles;
        end else begin
            mc_cnt_d = mc_cnt_q;
        end
    end

    // Multi-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_cnt_q <= {MC_W{1'b0}};
        end else begin
            mc_cnt_q <= mc_cnt_d;
        end
    end

    assign ex_busy_s = (mc_cnt_q != {MC_W{1'b0}});
`else
    logic unused_mc_s;
    assign unused_mc_s = ^{ex_mc_start, ex_mc_cycles};
    assign ex_busy_s   = 1'b0;
`endif

    // The ID instruction is being flushed when br fires, so its load-use hazard is moot.
    assign br_raw_s   = ex_br_taken && !(mem_wait_s || ex_busy_s);
    assign load_use_s = ex_mem_read && (ex_rd != 5'd0) && !br_raw_s &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // Prefix stall vector, deepest active source wins.
    always_comb begin
        stall_s = 6'b000000;
        if (mem_wait_s) begin
            stall_s = 6'b011111;
        end else if (ex_busy_s) begin
            stall_s = 6'b001111;
        end else if (load_use_s) begin
            stall_s = 6'b000111;
        end else begin
            stall_s = 6'b000000;
        end
    end

    // Stall-cycle performance counter, wraps naturally.
    always_comb begin
        if (stall_s[0]) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // FSM, timeout counter and performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstate_q    <= M_IDLE;
            to_cnt_q    <= 8'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            mstate_q    <= mstate_d;
            to_cnt_q    <= to_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall       = rst_n ? stall_s : 6'b000000;
    assign br          = rst_n && br_raw_s;
    assign mem_timeout = rst_n && mem_to_s;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: vector table, hand sequences and a randomized run
// against a cycle-count reference model.
module tb_pipe_stall_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, ex_mc_start;
    logic [4:0]  ex_mc_cycles;
    logic        mem_req, dmem_ready;
    logic [5:0]  stall;
    logic        br, mem_timeout;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: remaining EX busy cycles, cycles already spent waiting on memory,
    // and the expected performance counter.
    int          mc_rem   = 0;
    int          m_waited = 0;
    logic [31:0] m_cnt    = 32'd0;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, bt;
        logic [5:0] es;
        logic       eb;
    } vec_t;
    vec_t vecs[9];

    pipe_stall_ctrl #(.MEM_TIMEOUT(TO), .MC_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
        .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .stall(stall), .br(br), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic quiet();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0; ex_br_taken = 1'b0;
        ex_mc_start = 1'b0; ex_mc_cycles = 5'd0; mem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // One clock cycle: check outputs mid-cycle against the model (and optional hand
    // expectations), then advance the model and the clock.
    task automatic cyc(input bit hand, input logic [5:0] es, input logic eb, input logic et,
                       input string tag);
        bit mw, mt, busy, mb, lu;
        int nb;
        logic [5:0] ms;
        @(negedge clk);
        mw   = mem_req && !dmem_ready && (m_waited < TO);
        mt   = mem_req && !dmem_ready && (m_waited == TO);
        busy = (mc_rem > 0);
        mb   = ex_br_taken && !(mw || busy);
        lu   = ex_mem_read && (ex_rd != 5'd0) && !mb &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        nb   = mw ? 5 : (busy ? 4 : (lu ? 3 : 0));
        ms   = 6'((1 << nb) - 1);
        chk({tag, "/stall"}, 32'(stall), 32'(ms));
        chk({tag, "/br"}, 32'(br), 32'(mb));
        chk({tag, "/mem_timeout"}, 32'(mem_timeout), 32'(mt));
        chk({tag, "/stall_cnt"}, stall_cnt, m_cnt);
        if (hand) begin
            chk({tag, "/hand_stall"}, 32'(stall), 32'(es));
            chk({tag, "/hand_br"}, 32'(br), 32'(eb));
            chk({tag, "/hand_to"}, 32'(mem_timeout), 32'(et));
        end
        if (ms[0]) m_cnt = m_cnt + 32'd1;
        m_waited = mw ? m_waited + 1 : 0;
`ifdef PIPE_MC_EX_EN
        if (mc_rem > 0) mc_rem = mc_rem - 1;
        else if (ex_mc_start && ex_mc_cycles != 5'd0 && !mw) mc_rem = int'(ex_mc_cycles);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] base;
        vecs[0] = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b1, 1'b0, 6'b000111, 1'b0};
        vecs[1] = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 6'b000000, 1'b1};
        vecs[2] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 6'b000000, 1'b0};
        vecs[3] = '{5'd1,  5'd9,  5'd9,  1'b1, 1'b1, 1'b1, 1'b0, 6'b000111, 1'b0};
        vecs[4] = '{5'd1,  5'd9,  5'd9,  1'b1, 1'b0, 1'b1, 1'b0, 6'b000000, 1'b0};
        vecs[5] = '{5'd9,  5'd9,  5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 1'b0};
        vecs[6] = '{5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000111, 1'b0};
        vecs[7] = '{5'd3,  5'd4,  5'd5,  1'b1, 1'b1, 1'b1, 1'b1, 6'b000000, 1'b1};
        vecs[8] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0};

        // Reset state, with a would-be stall on the inputs.
        quiet();
        rst_n = 1'b0;
        mem_req = 1'b1;
        ex_br_taken = 1'b1;
        #3;
        chk("reset/stall", 32'(stall), 32'd0);
        chk("reset/br", 32'(br), 32'd0);
        chk("reset/stall_cnt", stall_cnt, 32'd0);
        quiet();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b1, 6'b000000, 1'b0, 1'b0, "idle");

        // Single-cycle load-use / branch table.
        for (int i = 0; i < 9; i++) begin
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_rd = vecs[i].rd;
            id_use_rs1 = vecs[i].u1; id_use_rs2 = vecs[i].u2;
            ex_mem_read = vecs[i].mr; ex_br_taken = vecs[i].bt;
            cyc(1'b1, vecs[i].es, vecs[i].eb, 1'b0, $sformatf("vec%0d", i));
        end
        quiet();

`ifdef PIPE_MC_EX_EN
        // Multi-cycle op of 3 with a branch waiting in EX.
        ex_mc_start = 1'b1; ex_mc_cycles = 5'd3; ex_br_taken = 1'b1;
        cyc(1'b1, 6'b000000, 1'b1, 1'b0, "mc_start");
        ex_mc_start = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 6'b001111, 1'b0, 1'b0, $sformatf("mc_busy%0d", i));
        cyc(1'b1, 6'b000000, 1'b1, 1'b0, "mc_done");
        quiet();
`else
        // Without the EX counter a start pulse has no effect.
        ex_mc_start = 1'b1; ex_mc_cycles = 5'd3;
        cyc(1'b1, 6'b000000, 1'b0, 1'b0, "mc_ign0");
        ex_mc_start = 1'b0;
        cyc(1'b1, 6'b000000, 1'b0, 1'b0, "mc_ign1");
        quiet();
`endif

        // Memory wait of 4 cycles then ready.
        base = m_cnt;
        mem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 6'b011111, 1'b0, 1'b0, $sformatf("mw%0d", i));
        dmem_ready = 1'b1;
        cyc(1'b1, 6'b000000, 1'b0, 1'b0, "mw_ready");
        chk("mw/stall_cnt_delta", stall_cnt, base + 32'd4);
        quiet();

        // Memory timeout: 8 stalled cycles, pulse on the 9th, then re-entry from idle.
        mem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < TO; i++) cyc(1'b1, 6'b011111, 1'b0, 1'b0, $sformatf("to%0d", i));
        cyc(1'b1, 6'b000000, 1'b0, 1'b1, "to_pulse");
        cyc(1'b1, 6'b011111, 1'b0, 1'b0, "to_reenter");
        mem_req = 1'b0;
        cyc(1'b1, 6'b000000, 1'b0, 1'b0, "to_drop");
        quiet();

        // Reset in the middle of an EX op and a memory wait.
`ifdef PIPE_MC_EX_EN
        ex_mc_start = 1'b1; ex_mc_cycles = 5'd3;
        cyc(1'b1, 6'b000000, 1'b0, 1'b0, "rst_mc_start");
        ex_mc_start = 1'b0;
`endif
        mem_req = 1'b1; dmem_ready = 1'b0;
        cyc(1'b1, 6'b011111, 1'b0, 1'b0, "rst_mw_enter");
        ex_br_taken = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid/stall", 32'(stall), 32'd0);
        chk("rst_mid/br", 32'(br), 32'd0);
        chk("rst_mid/mem_timeout", 32'(mem_timeout), 32'd0);
        chk("rst_mid/stall_cnt", stall_cnt, 32'd0);
        mc_rem = 0; m_waited = 0; m_cnt = 32'd0;
        quiet();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b1, 6'b000000, 1'b0, 1'b0, $sformatf("post_rst%0d", i));

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            id_use_rs1   = 1'($urandom_range(0, 1));
            id_use_rs2   = 1'($urandom_range(0, 1));
            ex_mem_read  = ($urandom_range(0, 2) == 0);
            ex_br_taken  = ($urandom_range(0, 5) == 0);
            ex_mc_start  = ($urandom_range(0, 7) == 0);
            ex_mc_cycles = 5'($urandom_range(0, 6));
            mem_req      = ($urandom_range(0, 3) != 0);
            dmem_ready   = ($urandom_range(0, 9) < 2);
            cyc(1'b0, 6'b000000, 1'b0, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
